// File: rtl/fma_postproc_sched.sv
// Scheduler for the shared FPU post-processor (normalize/round/format).
// Arbitrates FMA/CVT/DIV, drives datapath controls, tracks per-stage ops.
module fma_postproc_sched #(
    parameter  int PPLAT  = 2,
    parameter  int TAGW   = 5,
    parameter  int STARVE = 4,
    localparam int SW     = $clog2(STARVE + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             FmaValid_i,
    output logic             FmaReady_o,
    input  logic [TAGW-1:0]  FmaTag_i,
    input  logic             CvtValid_i,
    output logic             CvtReady_o,
    input  logic [TAGW-1:0]  CvtTag_i,
    input  logic             DivValid_i,
    output logic             DivReady_o,
    input  logic [TAGW-1:0]  DivTag_i,
    input  logic             Flush_i,
    output logic [1:0]       PostSel_o,
    output logic [PPLAT-1:0] PostEn_o,
    output logic             ResValid_o,
    input  logic             ResReady_i,
    output logic [TAGW-1:0]  ResTag_o,
    output logic [1:0]       ResSrc_o,
    output logic             Busy_o,
    output logic [SW-1:0]    StarveCnt_o
);

    localparam logic [1:0] SRC_FMA  = 2'd0;
    localparam logic [1:0] SRC_CVT  = 2'd1;
    localparam logic [1:0] SRC_DIV  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    logic [PPLAT-1:0] vld_q, vld_d;
    logic [TAGW-1:0]  tag_q [PPLAT];
    logic [TAGW-1:0]  tag_d [PPLAT];
    logic [1:0]       src_q [PPLAT];
    logic [1:0]       src_d [PPLAT];
    logic [SW-1:0]    starve_q, starve_d;

    logic            stall;
    logic            open;
    logic            cvt_pri;
    logic [1:0]      win;
    logic [1:0]      sel;
    logic [TAGW-1:0] acc_tag;

    assign stall   = vld_q[PPLAT-1] & ~ResReady_i;
    assign open    = ~stall & ~Flush_i & ~reset_i;
    assign cvt_pri = (starve_q == SW'(STARVE));

    // DIV always first; a starved CVT jumps ahead of the FMA
    always_comb begin
        win = SRC_NONE;
        if (DivValid_i)
            win = SRC_DIV;
        else if (cvt_pri && CvtValid_i)
            win = SRC_CVT;
        else if (FmaValid_i)
            win = SRC_FMA;
        else if (CvtValid_i)
            win = SRC_CVT;
    end

    always_comb begin
        sel     = open ? win : SRC_NONE;
        acc_tag = '0;
        unique case (sel)
            SRC_FMA: acc_tag = FmaTag_i;
            SRC_CVT: acc_tag = CvtTag_i;
            SRC_DIV: acc_tag = DivTag_i;
            default: acc_tag = '0;
        endcase
    end

    assign FmaReady_o = (sel == SRC_FMA);
    assign CvtReady_o = (sel == SRC_CVT);
    assign DivReady_o = (sel == SRC_DIV);
    assign PostSel_o  = sel;
    assign PostEn_o   = (reset_i || !stall) ? '1 : '0;

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        src_d = src_q;
        if (Flush_i) begin
            vld_d = '0;
            for (int i = 0; i < PPLAT; i++) begin
                tag_d[i] = '0;
                src_d[i] = SRC_NONE;
            end
        end else if (!stall) begin
            for (int i = PPLAT - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
                tag_d[i] = tag_q[i-1];
                src_d[i] = src_q[i-1];
            end
            vld_d[0] = (sel != SRC_NONE);
            tag_d[0] = acc_tag;
            src_d[0] = sel;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (Flush_i || !CvtValid_i || CvtReady_o)
            starve_d = '0;
        else if (!cvt_pri)
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q    <= '0;
            starve_q <= '0;
            for (int i = 0; i < PPLAT; i++) begin
                tag_q[i] <= '0;
                src_q[i] <= SRC_NONE;
            end
        end else begin
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            src_q    <= src_d;
            starve_q <= starve_d;
        end
    end

    assign ResValid_o  = vld_q[PPLAT-1];
    assign ResTag_o    = tag_q[PPLAT-1];
    assign ResSrc_o    = src_q[PPLAT-1];
    assign Busy_o      = |vld_q;
    assign StarveCnt_o = starve_q;

endmodule

// File: tb/tb_fma_postproc_sched.sv
// Directed bench for fma_postproc_sched with a result-tag scoreboard.
module tb_fma_postproc_sched;

    localparam int PPLAT = 2;
    localparam int TAGW  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            fv, cv, dv;
    logic            fr, cr, dr;
    logic [TAGW-1:0] ft, ct, dt;
    logic            flush;
    logic [1:0]      psel;
    logic [1:0]      pen;
    logic            rv, rr;
    logic [TAGW-1:0] rtag;
    logic [1:0]      rsrc;
    logic            busy;
    logic [2:0]      scnt;

    int checks = 0;
    int errors = 0;
    logic [6:0] sb_q [$];

    always #5 clk = ~clk;

    fma_postproc_sched #(.PPLAT(PPLAT), .TAGW(TAGW), .STARVE(4)) dut (
        .clk_i(clk), .reset_i(reset),
        .FmaValid_i(fv), .FmaReady_o(fr), .FmaTag_i(ft),
        .CvtValid_i(cv), .CvtReady_o(cr), .CvtTag_i(ct),
        .DivValid_i(dv), .DivReady_o(dr), .DivTag_i(dt),
        .Flush_i(flush), .PostSel_o(psel), .PostEn_o(pen),
        .ResValid_o(rv), .ResReady_i(rr), .ResTag_o(rtag),
        .ResSrc_o(rsrc), .Busy_o(busy), .StarveCnt_o(scnt)
    );

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard: pop on transfer, push on accept (src code fixed per producer)
    always @(negedge clk) begin
        if (rv === 1'b1 && rr === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {25'd0, rsrc, rtag}, 32'h7f);
            end else begin
                chk("sb_result", {25'd0, rsrc, rtag}, {25'd0, sb_q.pop_front()});
            end
        end
        if (fv === 1'b1 && fr === 1'b1) sb_q.push_back({2'd0, ft});
        if (cv === 1'b1 && cr === 1'b1) sb_q.push_back({2'd1, ct});
        if (dv === 1'b1 && dr === 1'b1) sb_q.push_back({2'd2, dt});
    end

    initial begin
        reset = 1'b1; flush = 1'b0; rr = 1'b1;
        fv = 1'b0; cv = 1'b0; dv = 1'b0;
        ft = '0; ct = '0; dt = '0;
        tick();
        fv = 1'b1; ft = 5'd1;
        #1;
        chk("rst_posten", pen, 2'b11);
        chk("rst_fready", fr, 0);
        chk("rst_postsel", psel, 3);
        fv = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_resvalid", rv, 0);
        chk("rst_restag", rtag, 0);
        chk("rst_ressrc", rsrc, 3);
        chk("rst_busy", busy, 0);
        chk("rst_idle_sel", psel, 3);
        chk("rst_starve", scnt, 0);

        // single op
        fv = 1'b1; ft = 5'd7;
        #1;
        chk("single_fready", fr, 1);
        chk("single_sel", psel, 0);
        tick();
        fv = 1'b0;
        #1;
        chk("single_busy", busy, 1);
        chk("single_rv_early", rv, 0);
        tick();
        chk("single_rv", rv, 1);
        chk("single_tag", rtag, 7);
        chk("single_src", rsrc, 0);
        tick();
        chk("single_rv_off", rv, 0);

        // fixed priority and starvation promotion
        fv = 1'b1; ft = 5'd1; cv = 1'b1; ct = 5'd2; dv = 1'b1; dt = 5'd3;
        #1;
        chk("pri0_div", dr, 1);
        chk("pri0_fma", fr, 0);
        chk("pri0_sel", psel, 2);
        tick();
        dv = 1'b0;
        #1;
        chk("pri1_fma", fr, 1);
        chk("pri1_starve", scnt, 1);
        tick();
        ft = 5'd4;
        #1;
        chk("pri2_fma", fr, 1);
        chk("pri2_starve", scnt, 2);
        tick();
        ft = 5'd5;
        #1;
        chk("pri3_fma", fr, 1);
        tick();
        ft = 5'd6;
        #1;
        chk("pri4_starve", scnt, 4);
        chk("pri4_cvt", cr, 1);
        chk("pri4_fma", fr, 0);
        chk("pri4_sel", psel, 1);
        tick();
        cv = 1'b0;
        #1;
        chk("pri5_starve", scnt, 0);
        chk("pri5_fma", fr, 1);
        tick();
        fv = 1'b0;
        repeat (3) tick();

        // back-pressure
        fv = 1'b1; ft = 5'd9;
        tick();
        ft = 5'd10;
        tick();
        ft = 5'd11; rr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_posten", pen, 0);
            chk("bp_ready", {fr, cr, dr}, 0);
            chk("bp_tag", rtag, 9);
            chk("bp_rv", rv, 1);
            tick();
        end
        rr = 1'b1;
        #1;
        chk("bp_lat_tag", rtag, 9);
        chk("bp_resume", fr, 1);
        tick();
        fv = 1'b0;
        #1;
        chk("bp_order", rtag, 10);
        repeat (3) tick();

        // flush with back-pressure
        fv = 1'b1; ft = 5'd4;
        tick();
        ft = 5'd5;
        tick();
        fv = 1'b0; rr = 1'b0; cv = 1'b1; ct = 5'd13;
        #1;
        chk("fl_tail", rtag, 4);
        tick();
        flush = 1'b1; fv = 1'b1; ft = 5'd12;
        #1;
        chk("fl_pre_starve", scnt, 1);
        chk("fl_fready", fr, 0);
        chk("fl_cready", cr, 0);
        tick();
        sb_q.delete();
        flush = 1'b0; cv = 1'b0; rr = 1'b1;
        #1;
        chk("fl_busy", busy, 0);
        chk("fl_rv", rv, 0);
        chk("fl_starve", scnt, 0);
        chk("fl_accept", fr, 1);
        tick();
        fv = 1'b0;
        repeat (3) tick();

        // reset mid-operation
        fv = 1'b1; ft = 5'd20;
        tick();
        ft = 5'd21;
        tick();
        fv = 1'b0; cv = 1'b1; ct = 5'd22; reset = 1'b1;
        #1;
        chk("mr_cready", cr, 0);
        chk("mr_sel", psel, 3);
        chk("mr_posten", pen, 2'b11);
        tick();
        sb_q.delete();
        reset = 1'b0;
        #1;
        chk("mr_rv", rv, 0);
        chk("mr_tag", rtag, 0);
        chk("mr_src", rsrc, 3);
        chk("mr_busy", busy, 0);
        chk("mr_starve", scnt, 0);
        chk("mr_cvt_grant", cr, 1);
        chk("mr_cvt_sel", psel, 1);
        tick();
        cv = 1'b0;
        repeat (3) tick();

        // streaming 20 FMA ops
        for (int k = 0; k < 22; k++) begin
            fv = (k < 20);
            ft = TAGW'(k);
            #1;
            if (k < 20) chk("st_fready", fr, 1);
            if (k >= 1) chk("st_busy", busy, 1);
            if (k >= 2) begin
                chk("st_rv", rv, 1);
                chk("st_tag", rtag, k - 2);
            end
            tick();
        end
        chk("st_rv_end", rv, 0);
        chk("st_busy_end", busy, 0);
        tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fma_postproc_sched.md
# fma_postproc_sched

Scheduler for the shared FPU post-processing pipeline: normalization shift, rounding and result formatting. Three producers compete for the single post-processor: the FMA, the converter and the divider. The block arbitrates between them, drives the operand-select and stage-enable controls of the post-processor datapath, and tracks which op occupies each post-processor stage. It also applies write-back back-pressure and flush, and returns the tag and source of each result to write-back.

## Interface
- PPLAT, default 2: post-processor pipeline depth in stages, at least 1.
- TAGW, default 5: destination tag width.
- STARVE, default 4: number of consecutive lost cycles before the converter is promoted over the FMA.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- FmaValid / FmaReady / FmaTag  in / out / in  1 / 1 / TAGW  FMA request handshake and tag.
- CvtValid / CvtReady / CvtTag  in / out / in  1 / 1 / TAGW  converter request handshake and tag.
- DivValid / DivReady / DivTag  in / out / in  1 / 1 / TAGW  divider request handshake and tag.
- Flush  in  1  discard every in-flight op and refuse new requests this cycle.
- PostSel  out  2  datapath input mux select: 0 FMA, 1 CVT, 2 DIV, 3 none.
- PostEn  out  PPLAT  per-stage register enable; bit i loads stage i+1.
- ResValid / ResReady  out / in  1 / 1  result handshake to write-back.
- ResTag / ResSrc  out  TAGW / 2  tag and source (same encoding as PostSel) of the result at the tail stage.
- Busy  out  1  at least one stage is valid.

## Operation
- **Per-stage state.** Each of stages 1..PPLAT holds valid, tag and source. The tail is stage PPLAT, and ResValid, ResTag and ResSrc come from the tail.
- **Stall.** Stall = ResValid & ~ResReady.
  - While Stall is high, no stage advances, PostEn is all zero and every Ready is low.
  - Bubbles do not collapse.
- **Advance.** When Stall is low, every stage advances by one and PostEn is all ones.
  - Stage 1 loads the granted request, or an invalid entry if there is no grant.
  - The tail is vacated when it transfers (ResValid & ResReady).
- **Priority.** DIV > FMA > CVT.
  - Exception: when StarveCnt == STARVE, the order is DIV > CVT > FMA.
  - Exactly one Ready is high, for the winner, and only if the request is valid, Stall is low and Flush is low.
  - The Ready signals are combinational from the Valid signals and state.
- **Acceptance.** A request is accepted when Valid & Ready are both high.
  - PostSel equals the winner's code in that same cycle; the datapath samples the operands at the edge.
  - When there is no winner, PostSel = 3.
- **Producer rule.** A producer must hold Valid and Tag stable until accepted. The scheduler does not check this.
- **StarveCnt.** Width is clog2(STARVE+1). Evaluated at each edge, in this order:
  - cleared on reset, on Flush, on a CVT accept, or when CvtValid is low;
  - otherwise incremented when CvtValid is high and CVT is not accepted, saturating at STARVE.
  - Stall cycles count as lost cycles.
- **Flush.** All stage valids clear at the edge and StarveCnt clears.
  - No request is accepted in the flush cycle.
  - Flush overrides Stall: the stages clear even if ResReady is low.
  - ResValid may be high during the flush cycle; a transfer that completes in that same cycle is honoured.
- **Reset values.**
  - All stages invalid with tag 0 and source 3, StarveCnt 0.
  - Outputs: ResValid 0, ResTag 0, ResSrc 3, Busy 0, PostSel 3, all Ready 0.
  - PostEn is all ones while reset is asserted, so the datapath flushes.

## Timing
- Accepted in cycle t with no stalls: the op is in stage 1 in cycle t+1 and ResValid is high in cycle t+PPLAT.
- Each stall cycle adds one cycle to the latency of every in-flight op.
- Throughput is one accept per cycle when ResReady is held high, so back-to-back accepts are legal.
- With PPLAT = 1, Stall depends on ResReady in the same cycle as acceptance. There is a combinational path ResReady → Ready, and it is permitted.
- Reset deasserted at edge e: the first accept is possible in the cycle following e.
- Simultaneous tail transfer and new accept while Stall is low: both occur, and occupancy is unchanged.

## Test plan
- **Single op.** PPLAT=2, single FMA request with tag 7 at cycle 3, ResReady=1.
  - FmaReady=1 and PostSel=0 in cycle 3.
  - ResValid=1, ResTag=7, ResSrc=0 in cycle 5, then ResValid=0 in cycle 6.
- **Fixed priority.** FMA, CVT and DIV all valid in cycle 0.
  - Grants in cycles 0, 1, 2 are DIV, FMA, FMA while FMA keeps issuing new requests.
  - CVT is granted once StarveCnt reaches 4, i.e. cycle 4; StarveCnt reads 0 in cycle 5.
- **Back-pressure.** Hold ResReady=0 for 3 cycles with the tail valid.
  - PostEn=0 and all Ready=0 for those 3 cycles, with no loss or reorder of tags.
  - Latency is 2+3 cycles for the stalled op.
- **Flush.** Flush with stages holding tags 4 and 5 and ResReady=0.
  - Next cycle: Busy=0, ResValid=0, StarveCnt=0.
  - A FmaValid presented in the flush cycle is accepted in the following cycle.
- **Reset mid-operation.** Reset while 2 ops are in flight and CvtValid=1.
  - All outputs take their reset values in the next cycle.
  - The held CvtValid is granted one cycle after reset drops.
- **Streaming.** Stream 20 FMA ops with ResReady=1.
  - 20 results in consecutive cycles, tags in issue order.
  - Busy=1 from the first accept+1 through the last result.
